sprite_draw_scheduler: RTL and testbench

Per-frame sequencer that sits directly upstream of the framebuffer and drives the sprite drawer blocks. On each frame_start it optionally clears the framebuffer to a background index. It then starts each enabled sprite drawer in index order and turns each drawer's free-running X/Y/color_index stream into registered framebuffer write cycles. Transparent and off-screen pixels are discarded.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/fb_write_stage.sv | 69 ++++++
 rtl/sprite_draw_scheduler.sv | 129 ++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared screen geometry, pixel record and scheduler state encoding for the sprite drawing path.
package draw_pkg;

  localparam int unsigned SCR_W = 320;
  localparam int unsigned SCR_H = 240;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [6:0] color;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SELECT,
    LAUNCH,
    STREAM,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/fb_write_stage.sv
// Framebuffer write register: muxes clear writes against drawer pixels, filters
// transparent/off-screen pixels and forms the linear address.
module fb_write_stage
  import draw_pkg::*;
#(
  parameter int unsigned W      = draw_pkg::SCR_W,
  parameter int unsigned H      = draw_pkg::SCR_H,
  parameter logic [6:0]  TRANSP = 7'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr_valid,
  input  logic [16:0] i_clr_addr,
  input  logic [6:0]  i_clr_data,
  input  logic        i_pix_valid,
  input  pixel_t      i_pix,
  output logic        o_we,
  output logic [16:0] o_addr,
  output logic [6:0]  o_data
);

  logic        w_pix_ok;
  logic [16:0] w_pix_addr;
  logic        w_we;
  logic [16:0] w_addr;
  logic [6:0]  w_data;
  logic        r_we;
  logic [16:0] r_addr;
  logic [6:0]  r_data;

  assign w_pix_ok = i_pix_valid
                 && (i_pix.color != TRANSP)
                 && ({1'b0, i_pix.x} < 10'(W))
                 && ({1'b0, i_pix.y} < 9'(H));

  assign w_pix_addr = 17'(i_pix.y) * 17'(W) + 17'(i_pix.x);

  always_comb begin
    w_we   = 1'b0;
    w_addr = w_pix_addr;
    w_data = i_pix.color;
    if (i_clr_valid) begin
      w_we   = 1'b1;
      w_addr = i_clr_addr;
      w_data = i_clr_data;
    end else if (w_pix_ok) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_we;
      if (w_we) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sequencer: optional background clear, then each enabled sprite drawer in
// index order, converting the selected drawer's pixel stream into framebuffer writes.
module sprite_draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned N_SPR  = 4,
  parameter int unsigned SCR_W  = draw_pkg::SCR_W,
  parameter int unsigned SCR_H  = draw_pkg::SCR_H,
  parameter logic [6:0]  TRANSP = 7'd0,
  parameter logic [6:0]  BG_IDX = 7'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               clear_en,
  input  logic [N_SPR-1:0]   spr_en,
  output logic [N_SPR-1:0]   spr_start,
  input  logic [N_SPR-1:0]   spr_done,
  input  logic [9*N_SPR-1:0] spr_x,
  input  logic [8*N_SPR-1:0] spr_y,
  input  logic [7*N_SPR-1:0] spr_color,
  output logic               fb_we,
  output logic [16:0]        fb_addr,
  output logic [6:0]         fb_data,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int unsigned KW       = $clog2(N_SPR + 1);
  localparam logic [16:0] CLR_LAST = 17'(SCR_W * SCR_H - 1);

  sched_state_t   r_state;
  sched_state_t   w_next;
  logic [KW-1:0]  r_k;
  logic [16:0]    r_clr_addr;
  logic [N_SPR-1:0] r_en;
  logic           r_overrun;

  logic           w_at_end;
  logic           w_sel_en;
  logic           w_sel_done;
  pixel_t         w_sel_pix;

  // Only drawer k's bus is observed; everything else is don't-care.
  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_done = 1'b0;
    w_sel_pix  = '0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      if (r_k == KW'(i)) begin
        w_sel_en   = r_en[i];
        w_sel_done = spr_done[i];
        w_sel_pix  = {spr_x[9*i +: 9], spr_y[8*i +: 8], spr_color[7*i +: 7]};
      end
    end
  end

  assign w_at_end = (r_k == KW'(N_SPR));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (frame_start) w_next = clear_en ? CLEAR : SELECT;
      CLEAR:  if (r_clr_addr == CLR_LAST) w_next = SELECT;
      SELECT: begin
        if (w_at_end)      w_next = FINISH;
        else if (w_sel_en) w_next = LAUNCH;
      end
      LAUNCH: w_next = STREAM;
      STREAM: if (w_sel_done) w_next = SELECT;
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_clr_addr <= '0;
      r_en       <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_overrun <= frame_start && (r_state != IDLE);
      unique case (r_state)
        IDLE: if (frame_start) begin
          r_en       <= spr_en;
          r_k        <= '0;
          r_clr_addr <= '0;
        end
        CLEAR:  r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + 17'd1;
        SELECT: if (!w_at_end && !w_sel_en) r_k <= r_k + 1'b1;
        STREAM: if (w_sel_done) r_k <= r_k + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    spr_start = '0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      if ((r_state == LAUNCH) && (r_k == KW'(i))) spr_start[i] = 1'b1;
    end
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == FINISH);
  assign overrun    = r_overrun;

  fb_write_stage #(
    .W      (SCR_W),
    .H      (SCR_H),
    .TRANSP (TRANSP)
  ) u_wr (
    .clk         (clk),
    .reset       (reset),
    .i_clr_valid (r_state == CLEAR),
    .i_clr_addr  (r_clr_addr),
    .i_clr_data  (BG_IDX),
    .i_pix_valid ((r_state == STREAM) && !w_sel_done),
    .i_pix       (w_sel_pix),
    .o_we        (fb_we),
    .o_addr      (fb_addr),
    .o_data      (fb_data)
  );

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: rectangle drawer models, a list-based frame model,
// table vectors, hand-written corner sequences and randomized frames.
module tb_sprite_draw_scheduler;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [3:0] w;
    logic [3:0] h;
    logic [6:0] c;
  } rect_t;

  typedef struct {
    logic [3:0] en;
    rect_t      r0, r1, r2, r3;
    int         exp_writes;
    int         exp_first;
    int         exp_last;
    int         exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, frame_start, clear_en;
  logic [3:0]  spr_en, spr_start, spr_done;
  logic [35:0] spr_x;
  logic [31:0] spr_y;
  logic [27:0] spr_color;
  logic        fb_we, busy, frame_done, overrun;
  logic [16:0] fb_addr;
  logic [6:0]  fb_data;

  logic [23:0] pmem [4][256];
  int          plen [4];

  int wa[$], wd[$], wc[$], start_log[$], done_log[$];
  int ea[$], ed[$], es[$];
  int exp_lat, lat_got;
  int cyc = 0, ovr_cnt = 0, viol = 0;
  int checks = 0, failures = 0;

  sprite_draw_scheduler #(
    .N_SPR  (4),
    .SCR_W  (320),
    .SCR_H  (240),
    .TRANSP (7'd0),
    .BG_IDX (7'd1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .clear_en    (clear_en),
    .spr_en      (spr_en),
    .spr_start   (spr_start),
    .spr_done    (spr_done),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_color   (spr_color),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
    $fatal(1);
  end

  // Output monitor: cycle numbers are assigned at each falling edge.
  always @(negedge clk) begin
    cyc++;
    if (fb_we) begin
      wa.push_back(int'(fb_addr));
      wd.push_back(int'(fb_data));
      wc.push_back(cyc);
    end
    if (frame_done) done_log.push_back(cyc);
    if (overrun) ovr_cnt++;
  end

  // Drawer models: pixels in t+1..t+P after a start in t, done in t+P+1; idle buses carry noise.
  initial begin : drawers
    int act, ak, idx;
    act = 0; ak = 0; idx = 0;
    forever begin
      @(posedge clk); #1;
      spr_x     = 36'({$urandom(), $urandom()});
      spr_y     = $urandom();
      spr_color = 28'($urandom());
      spr_done  = 4'($urandom());
      if (act != 0) begin
        if (idx < plen[ak]) begin
          spr_x[9*ak +: 9]     = pmem[ak][idx][23:15];
          spr_y[8*ak +: 8]     = pmem[ak][idx][14:7];
          spr_color[7*ak +: 7] = pmem[ak][idx][6:0];
          spr_done[ak]         = 1'b0;
          idx++;
        end else begin
          spr_done[ak] = 1'b1;
          act = 0;
        end
      end
      if (spr_start != 4'b0) begin
        if (act != 0) viol++;
        if ($countones(spr_start) != 1) viol++;
        for (int i = 0; i < 4; i++) if (spr_start[i]) ak = i;
        start_log.push_back(ak);
        act = 1;
        idx = 0;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic rect_t R(input int x, input int y, input int w, input int h, input int c);
    R = {9'(x), 8'(y), 4'(w), 4'(h), 7'(c)};
  endfunction

  task automatic set_rect(input int k, input rect_t r);
    int n;
    n = 0;
    for (int yy = 0; yy < int'(r.h); yy++)
      for (int xx = 0; xx < int'(r.w); xx++) begin
        pmem[k][n] = {9'(int'(r.x) + xx), 8'(int'(r.y) + yy), r.c};
        n++;
      end
    plen[k] = n;
  endtask

  // Reference frame: clear list, then each enabled drawer's visible pixels in drawer order.
  task automatic build_model(input bit clr, input logic [3:0] en);
    int cost, x, y, c;
    ea.delete(); ed.delete(); es.delete();
    cost = 0;
    if (clr) for (int i = 0; i < 320*240; i++) begin ea.push_back(i); ed.push_back(1); end
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        es.push_back(k);
        cost += plen[k] + 3;
        for (int p = 0; p < plen[k]; p++) begin
          x = int'(pmem[k][p][23:15]);
          y = int'(pmem[k][p][14:7]);
          c = int'(pmem[k][p][6:0]);
          if (c != 0 && x < 320 && y < 240) begin
            ea.push_back(y*320 + x);
            ed.push_back(c);
          end
        end
      end else begin
        cost += 1;
      end
    end
    exp_lat = 1 + (clr ? 320*240 : 0) + cost + 1;
  endtask

  task automatic run_frame(input string tag, input bit clr, input logic [3:0] en, input int ovr_at);
    int fs, nd0, ovr0, c, mism, budget;
    build_model(clr, en);
    wa.delete(); wd.delete(); wc.delete(); start_log.delete();
    nd0 = done_log.size();
    ovr0 = ovr_cnt;
    budget = exp_lat + 40;
    @(posedge clk); #1;
    frame_start = 1'b1; clear_en = clr; spr_en = en;
    fs = cyc + 1;
    chk({tag, "_busy_before"}, int'(busy), 0);
    @(posedge clk); #1;
    frame_start = 1'b0; clear_en = 1'($urandom()); spr_en = 4'($urandom());
    chk({tag, "_busy_rise"}, int'(busy), 1);
    c = 1;
    while (done_log.size() == nd0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      frame_start = (c == ovr_at);
    end
    frame_start = 1'b0;
    chk({tag, "_busy_fall"}, int'(busy), 0);
    lat_got = (done_log.size() > nd0) ? done_log[nd0] - fs : -1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_frame_done_once"}, done_log.size() - nd0, 1);
    chk({tag, "_latency"}, lat_got, exp_lat);
    chk({tag, "_write_count"}, wa.size(), ea.size());
    mism = 0;
    if (wa.size() != ea.size()) mism++;
    else for (int i = 0; i < wa.size(); i++) if (wa[i] != ea[i] || wd[i] != ed[i]) mism++;
    chk({tag, "_write_list_mismatches"}, mism, 0);
    mism = 0;
    if (start_log.size() != es.size()) mism++;
    else for (int i = 0; i < es.size(); i++) if (start_log[i] != es[i]) mism++;
    chk({tag, "_start_order_mismatches"}, mism, 0);
    chk({tag, "_overrun_pulses"}, ovr_cnt - ovr0, (ovr_at > 0) ? 1 : 0);
    chk({tag, "_last_write_before_done"},
        (wc.size() > 0 && lat_got >= 0 && wc[wc.size()-1] >= fs + lat_got) ? 1 : 0, 0);
    chk({tag, "_drawer_protocol_violations"}, viol, 0);
    if (clr) begin
      mism = 0;
      for (int i = 1; i < wc.size(); i++) if (wc[i] != wc[0] + i) mism++;
      chk({tag, "_clear_gaps"}, mism, 0);
      chk({tag, "_clear_first_latency"}, (wc.size() > 0) ? wc[0] - fs : -1, 2);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'b0000, R(1,1,1,1,1), R(1,1,1,1,1), R(1,1,1,1,1), R(1,1,1,1,1),
                0, -1, -1, 6};
    vecs[1] = '{4'b0001, R(105,60,11,12,5), R(3,3,2,2,9), R(4,4,2,2,9), R(5,5,2,2,9),
                132, 19305, 22835, 140};
    vecs[2] = '{4'b1010, R(50,50,3,3,4), R(0,0,4,2,9), R(60,60,3,3,4), R(316,238,4,2,127),
                16, 0, 76799, 26};
    vecs[3] = '{4'b1111, R(10,10,2,2,0), R(0,239,1,2,2), R(318,0,4,1,3), R(5,5,1,1,6),
                4, 76480, 1605, 25};
    vecs[4] = '{4'b1111, R(10,10,1,1,0), R(330,5,1,1,3), R(5,240,1,1,3), R(319,239,1,1,3),
                1, 76799, 76799, 18};

    for (int k = 0; k < 4; k++) plen[k] = 0;
    reset = 1'b1; frame_start = 1'b0; clear_en = 1'b0; spr_en = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_spr_start", int'(spr_start), 0);
    chk("reset_fb_we", int'(fb_we), 0);
    chk("reset_fb_addr", int'(fb_addr), 0);
    chk("reset_fb_data", int'(fb_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      set_rect(0, vecs[v].r0);
      set_rect(1, vecs[v].r1);
      set_rect(2, vecs[v].r2);
      set_rect(3, vecs[v].r3);
      run_frame($sformatf("vec%0d", v), 1'b0, vecs[v].en, 0);
      chk($sformatf("vec%0d_table_writes", v), wa.size(), vecs[v].exp_writes);
      chk($sformatf("vec%0d_table_first", v), (wa.size() > 0) ? wa[0] : -1, vecs[v].exp_first);
      chk($sformatf("vec%0d_table_last", v), (wa.size() > 0) ? wa[wa.size()-1] : -1, vecs[v].exp_last);
      chk($sformatf("vec%0d_table_latency", v), lat_got, vecs[v].exp_lat);
    end

    run_frame("clear", 1'b1, 4'b0000, 0);
    chk("clear_table_writes", wa.size(), 76800);
    chk("clear_table_last", (wa.size() > 0) ? wa[wa.size()-1] : -1, 76799);
    chk("clear_table_latency", lat_got, 76806);

    set_rect(0, vecs[1].r0);
    run_frame("overrun", 1'b0, 4'b0001, 30);

    // Reset while drawer 0 is mid-stream; the drawer itself keeps running to completion.
    @(posedge clk); #1;
    frame_start = 1'b1; clear_en = 1'b0; spr_en = 4'b0001;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_spr_start", int'(spr_start), 0);
    chk("midreset_fb_we", int'(fb_we), 0);
    chk("midreset_fb_addr", int'(fb_addr), 0);
    chk("midreset_fb_data", int'(fb_data), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_frame_done", int'(frame_done), 0);
    chk("midreset_overrun", int'(overrun), 0);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    run_frame("after_reset", 1'b0, 4'b0001, 0);
    chk("after_reset_first", (wa.size() > 0) ? wa[0] : -1, 19305);

    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++)
        set_rect(k, R($urandom_range(0, 330), $urandom_range(0, 245), $urandom_range(1, 6),
                      $urandom_range(1, 6), $urandom_range(0, 7)));
      run_frame($sformatf("rand%0d", f), 1'b0, 4'($urandom()), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
